// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: operand handshake plus product-register bus of mul_seq_ctrl.
// The slave modport is the controller view; the master modport is the
// requester / product-register view. The ovf signal exists only when
// MUL_OVF_EN is defined.
interface mul_seq_ctrl_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] pipo_q;
  logic        pipo_ld;
  logic        pipo_clr;
  logic [15:0] pipo_din;
  logic        busy;
  logic        done;
`ifdef MUL_OVF_EN
  logic        ovf;

  modport master (
    output start, a, b, pipo_q,
    input  pipo_ld, pipo_clr, pipo_din, busy, done, ovf
  );

  modport slave (
    input  start, a, b, pipo_q,
    output pipo_ld, pipo_clr, pipo_din, busy, done, ovf
  );
`else
  modport master (
    output start, a, b, pipo_q,
    input  pipo_ld, pipo_clr, pipo_din, busy, done
  );

  modport slave (
    input  start, a, b, pipo_q,
    output pipo_ld, pipo_clr, pipo_din, busy, done
  );
`endif
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-free sequential multiplier controller.
// Multiplies a by b by repeated addition into an external product register
// (pipo) that has synchronous clear and load. Sequence per operation:
//   IDLE --start--> CLEAR (1 cycle) --> ADD (b cycles) --> DONE (1 cycle) --> IDLE
// All control outputs are registered and decoded from the next state.
// pipo_din is the fed-back product plus the captured multiplicand; it has to
// be combinational from pipo_q because the register updates on the same edge
// that would otherwise register it. It is forced to zero whenever pipo_ld=0.
// clr is a synchronous, active-low reset.
// Optional feature: define MUL_OVF_EN to add the sticky overflow output ovf.
module mul_seq_ctrl (
  input  logic          clk,
  input  logic          clr,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] a_r_q;
  logic [15:0] a_r_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        busy_q;
  logic        busy_d;
  logic        done_q;
  logic        done_d;
  logic        pipo_ld_q;
  logic        pipo_ld_d;
  logic        pipo_clr_q;
  logic        pipo_clr_d;

`ifdef MUL_OVF_EN
  logic        ovf_q;
  logic        ovf_d;
  // 17-bit sum so the carry out of bit 15 is visible for ovf.
  logic [16:0] sum_s;
  assign sum_s = {1'b0, bus.pipo_q} + {1'b0, a_r_q};
`else
  logic [15:0] sum_s;
  assign sum_s = bus.pipo_q + a_r_q;
`endif

  // Next-state, operand capture, counter and strobe decode.
  always_comb begin
    state_d = state_q;
    a_r_d   = a_r_q;
    cnt_d   = cnt_q;
`ifdef MUL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Operands are latched here so later changes on a/b are ignored.
          state_d = ST_CLEAR;
          a_r_d   = bus.a;
          cnt_d   = bus.b;
`ifdef MUL_OVF_EN
          // Cleared on entry so ovf already reads 0 during CLEAR.
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q != 16'd0) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ADD: begin
        // Guard against wrap: a zero count in ADD is unreachable but must
        // not turn into a 65535-cycle run.
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d = 16'd0;
        end
        if (cnt_q <= 16'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ADD;
        end
`ifdef MUL_OVF_EN
        ovf_d = ovf_q | sum_s[16];
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes follow the state they belong to, one flop stage ahead.
    busy_d     = (state_d != ST_IDLE);
    pipo_clr_d = (state_d == ST_CLEAR);
    pipo_ld_d  = (state_d == ST_ADD);
    done_d     = (state_d == ST_DONE);
  end

  // Single state register for FSM, operands and outputs; clr=0 forces IDLE.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      a_r_q      <= 16'd0;
      cnt_q      <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pipo_ld_q  <= 1'b0;
      pipo_clr_q <= 1'b0;
`ifdef MUL_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_r_q      <= a_r_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pipo_ld_q  <= pipo_ld_d;
      pipo_clr_q <= pipo_clr_d;
`ifdef MUL_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pipo_ld  = pipo_ld_q;
  assign bus.pipo_clr = pipo_clr_q;
  assign bus.pipo_din = pipo_ld_q ? sum_s[15:0] : 16'd0;
`ifdef MUL_OVF_EN
  assign bus.ovf      = ovf_q;
`endif

endmodule
